// File: rtl/ps2_scancode_decoder_if.sv
// Scan-code input and key-event output bundle of the PS/2 scan-code decoder.
// The slave side is the decoder; the master side is the deserialiser/consumer.
interface ps2_scancode_decoder_if;
    logic       valid_scan_code;
    logic [7:0] scan_code;
    logic       evt_valid;
    logic [9:0] evt_data;
    logic       evt_ready;
    logic       overflow;
    logic       proto_err;

    modport slave (
        input  valid_scan_code, scan_code, evt_ready,
        output evt_valid, evt_data, overflow, proto_err
    );

    modport master (
        output valid_scan_code, scan_code, evt_ready,
        input  evt_valid, evt_data, overflow, proto_err
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code prefix decoder (E0/F0/E1) with status-byte filtering,
// prefix timeout and a show-ahead event FIFO.
module ps2_scancode_decoder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 2000000
) (
    input logic                   clk,
    input logic                   reset_n,
    ps2_scancode_decoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

    function automatic logic is_status(input logic [7:0] b);
        case (b)
            8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    state_t        r_state, w_next;
    logic          r_valid_d;
    logic [2:0]    r_pause_cnt, w_pause_nxt;
    logic [TW-1:0] r_tmo_cnt;
    logic          w_byte_stb, w_timeout, w_emit, w_perr;
    logic [9:0]    w_evt;
    logic [7:0]    w_b;

    logic [9:0]    r_mem [DEPTH];
    logic [AW:0]   r_wptr, r_rptr;
    logic [9:0]    r_last;
    logic          r_ovf, r_perr;
    logic          w_empty, w_full, w_pop, w_push, w_drop;

    assign w_b        = bus.scan_code;
    assign w_byte_stb = bus.valid_scan_code & ~r_valid_d;
    assign w_timeout  = (r_state != S_IDLE) && (r_tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_valid_d   <= 1'b1;
            r_pause_cnt <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            r_state     <= w_next;
            r_valid_d   <= bus.valid_scan_code;
            r_pause_cnt <= w_pause_nxt;
            if (w_byte_stb || r_state == S_IDLE || w_timeout)
                r_tmo_cnt <= '0;
            else
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    // A byte arriving in the timeout cycle is decoded in the current state.
    always_comb begin
        w_next      = r_state;
        w_pause_nxt = r_pause_cnt;
        w_emit      = 1'b0;
        w_evt       = '0;
        w_perr      = 1'b0;
        if (w_byte_stb) begin
            case (r_state)
                S_IDLE: begin
                    if (w_b == 8'hE0) w_next = S_EXT;
                    else if (w_b == 8'hF0) w_next = S_BRK;
                    else if (w_b == 8'hE1) begin
                        w_next      = S_PAUSE;
                        w_pause_nxt = '0;
                    end else if (!is_status(w_b)) begin
                        w_emit = 1'b1;
                        w_evt  = {2'b00, w_b};
                    end
                end
                S_EXT: begin
                    if (w_b == 8'hF0) w_next = S_EXT_BRK;
                    else if (w_b == 8'hE0) w_next = S_EXT;
                    else if (w_b == 8'h12 || w_b == 8'h59) w_next = S_IDLE;
                    else if (w_b == 8'hE1) begin
                        w_perr = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_emit = 1'b1;
                        w_evt  = {2'b01, w_b};
                        w_next = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_next = S_IDLE;
                    if (w_b == 8'hE0 || w_b == 8'hF0 || w_b == 8'hE1) w_perr = 1'b1;
                    else begin
                        w_emit = 1'b1;
                        w_evt  = {2'b10, w_b};
                    end
                end
                S_EXT_BRK: begin
                    w_next = S_IDLE;
                    if (w_b == 8'hE0 || w_b == 8'hF0 || w_b == 8'hE1) w_perr = 1'b1;
                    else if (w_b != 8'h12 && w_b != 8'h59) begin
                        w_emit = 1'b1;
                        w_evt  = {2'b11, w_b};
                    end
                end
                S_PAUSE: begin
                    // Seven bytes follow the leading E1; only their count matters.
                    if (r_pause_cnt == 3'd6) begin
                        w_emit = 1'b1;
                        w_evt  = 10'h177;
                        w_next = S_IDLE;
                    end else begin
                        w_pause_nxt = r_pause_cnt + 3'd1;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_next = S_IDLE;
        end
    end

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = bus.evt_ready & ~w_empty;
    assign w_push  = w_emit & (~w_full | w_pop);
    assign w_drop  = w_emit & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_last <= '0;
            r_ovf  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= w_evt;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_last <= r_mem[r_rptr[AW-1:0]];
                r_rptr <= r_rptr + 1'b1;
            end
            r_ovf  <= w_drop;
            r_perr <= w_perr;
        end
    end

    // While empty, the output keeps showing the most recently popped head.
    assign bus.evt_valid = ~w_empty;
    assign bus.evt_data  = w_empty ? r_last : r_mem[r_rptr[AW-1:0]];
    assign bus.overflow  = r_ovf;
    assign bus.proto_err = r_perr;
endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 serial-to-scancode deserialiser.
- Consumes raw Set-2 scan-code bytes and tracks the E0 (extended), F0 (break) and E1 (pause) prefix sequences.
- Filters keyboard status bytes and emits one key event per complete key action.
- Events are buffered in a small show-ahead FIFO with a valid/ready read handshake, for the keycode/display logic.

Parameters:
- DEPTH, 4, event FIFO entries; power of two, minimum 2.
- TIMEOUT, 2000000, clk cycles a partial prefix sequence may wait for its next byte before it is abandoned (20 ms at 100 MHz).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- valid_scan_code  in  1  high when scan_code holds a new byte; may stay high for many cycles; only its rising edge counts.
- scan_code  in  8  byte from the deserialiser; stable while valid_scan_code is high.
- evt_valid  out  1  FIFO non-empty.
- evt_data  out  10  head event: [9]=release, [8]=extended, [7:0]=key code.
- evt_ready  in  1  consumer pops the head when evt_valid and evt_ready are both high.
- overflow  out  1  1-cycle pulse: an event was dropped because the FIFO was full.
- proto_err  out  1  1-cycle pulse: illegal prefix order detected.

Behaviour:
Reset:
- Reset is asynchronous; clk is the only clock.
- During reset: evt_valid=0, evt_data=0, overflow=0, proto_err=0, FSM=IDLE, FIFO empty, timeout counter=0.
- The edge-detect register resets to 1, so a valid_scan_code held high across reset release is not taken as a new byte.
- Reset mid-sequence or mid-FIFO discards everything.

Byte strobe and latency:
- byte_stb = valid_scan_code & ~valid_d, with valid_d registered each cycle.
- scan_code is sampled in the byte_stb cycle.
- Latency: an event produced by the byte_stb in cycle N is written at the end of cycle N; evt_valid is high in cycle N+1 if the FIFO was empty.

FSM (on byte_stb only; b = sampled byte):
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, pause count cleared.
  - 00, FF, AA, FA, EE, FE, FC -> discarded, stay IDLE.
  - Any other byte -> emit {0,0,b}, stay IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT.
  - 12 or 59 (fake shift) -> discarded, go to IDLE.
  - E1 -> proto_err, go to IDLE.
  - Any other byte -> emit {0,1,b}, go to IDLE.
- BRK:
  - E0, F0 or E1 -> proto_err, go to IDLE, no event.
  - Any other byte -> emit {1,0,b}, go to IDLE.
- EXT_BRK:
  - 12 or 59 -> discarded, go to IDLE.
  - E0, F0 or E1 -> proto_err, go to IDLE.
  - Any other byte -> emit {1,1,b}, go to IDLE.
- PAUSE:
  - Byte contents are ignored; count the bytes.
  - On the 7th byte after E1 (the full sequence is E1 14 77 E1 F0 14 F0 77), emit {0,1,0x77} and go to IDLE.

Timeout:
- The counter runs only in states other than IDLE, and clears on every byte_stb.
- When it reaches TIMEOUT-1: FSM -> IDLE, no event, no proto_err.
- A byte_stb in the same cycle as the timeout wins: the byte is processed in the current state.

FIFO:
- Show-ahead: evt_data is the head entry, valid whenever evt_valid=1.
- Push when an event is emitted and the FIFO is not full.
- Full with no pop: the new event is dropped and overflow pulses; FIFO contents are unchanged.
- Full with a simultaneous pop: the push is accepted, occupancy stays DEPTH, no overflow.
- Empty with a push: no same-cycle bypass; evt_valid rises the next cycle.
- Pop with evt_valid=0 is ignored.
- Pointers wrap modulo DEPTH; occupancy is tracked with an extra pointer bit.
- evt_data is undefined-safe: it holds the last head value, or 0 after reset, while empty.

Test Plan:
- Bytes 1C then F0 1C (valid held 50 cycles each, evt_ready=1) -> events 0x01C, then 0x21C; no duplicate events while valid stays high.
- E0 75, E0 F0 75 -> 0x175, then 0x375; E0 12 E0 70 -> 0x170 only, with the fake shift discarded.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event, 0x177; FSM back in IDLE; a following 1C -> 0x01C.
- evt_ready=0, six make codes 15 1D 24 2D 2C 35 (DEPTH=4) -> FIFO holds 015 01D 024 02D; two overflow pulses; popping returns the four in order.
- FIFO full, then a push and pop in the same cycle -> no overflow, occupancy 4, new tail correct.
- F0 then an idle gap longer than TIMEOUT (bench TIMEOUT=100), then 1C -> event 0x01C (make, not break).
- F0 F0 -> one proto_err pulse, no event.
- Assert reset_n low mid-sequence after E0 -> evt_valid=0 immediately; after release with valid_scan_code still high, no event is produced.
